// File: rtl/menu_scroller_if.sv
// ============================================================================
// Module      : menu_scroller_if
// Description : Menu bus between the game state machine, the menu scroller
//               and the display driver. presente carries the game state in;
//               display_menu and scroll_wrap carry the text window out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface menu_scroller_if;
  logic [2:0]  presente;
  logic [27:0] display_menu;
  logic        scroll_wrap;

  // Game-side view: drives the state, observes the text window
  modport master (
    output presente,
    input  display_menu,
    input  scroll_wrap
  );

  // Scroller-side view
  modport slave (
    input  presente,
    output display_menu,
    output scroll_wrap
  );
endinterface

`default_nettype wire

// File: rtl/menu_scroller.sv
// ============================================================================
// Module      : menu_scroller
// Description : Scrolling 4-character 7-segment text engine for the welcome
//               (WLCM) and character-select (CH) game states. A tick divider
//               paces the scroll; the window rests HOLD_STEPS ticks at index 0
//               before scrolling through the message, then wraps and holds
//               again. Output is blank in every other game state.
//               Optional macro MENU_BLINK_EN: blink the window during HOLD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module menu_scroller #(
  parameter int SCROLL_DIV = 13_500_000,
  parameter int HOLD_STEPS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  menu_scroller_if.slave  bus
);

  localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(SCROLL_DIV - 1);
  localparam logic [3:0]    HOLD_MAX = 4'(HOLD_STEPS - 1);

  localparam logic [2:0] P_WLCM = 3'd1;
  localparam logic [2:0] P_CH   = 3'd2;

  localparam logic [3:0] LEN_WLCM = 4'd13;
  localparam logic [3:0] LEN_CH   = 4'd14;

  // Glyphs, bit6..bit0 = segments a..g
  localparam logic [6:0] G_H  = 7'b0110111;
  localparam logic [6:0] G_O  = 7'b1111110;
  localparam logic [6:0] G_L  = 7'b0001110;
  localparam logic [6:0] G_A  = 7'b1110111;
  localparam logic [6:0] G_E  = 7'b1001111;
  localparam logic [6:0] G_R  = 7'b0000101;
  localparam logic [6:0] G_I  = 7'b0110000;
  localparam logic [6:0] G_G  = 7'b1011110;
  localparam logic [6:0] G_BL = 7'b0000000;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HOLD   = 2'd1,
    S_SCROLL = 2'd2
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]    idx, idx_nx;
  logic [3:0]    hold_cnt, hold_nx;
  logic          msg_sel, sel_nx;      // 0 = WLCM text, 1 = CH text
  logic          wrap_q, wrap_nx;
  logic [27:0]   disp_q, disp_nx;
  logic          tick;
  logic          req_active;
  logic          req_sel;

  // Message ROM: sel 0 = "HOLA HErOE   ", sel 1 = "ELIGE HErOE   "
  function automatic logic [6:0] glyph(input logic sel, input logic [4:0] pos);
    logic [6:0] g;
    g = G_BL;
    if (!sel) begin
      case (pos)
        5'd0: g = G_H;  5'd1: g = G_O;  5'd2: g = G_L;  5'd3: g = G_A;
        5'd5: g = G_H;  5'd6: g = G_E;  5'd7: g = G_R;  5'd8: g = G_O;
        5'd9: g = G_E;
        default: g = G_BL;
      endcase
    end else begin
      case (pos)
        5'd0:  g = G_E; 5'd1:  g = G_L; 5'd2: g = G_I; 5'd3: g = G_G;
        5'd4:  g = G_E; 5'd6:  g = G_H; 5'd7: g = G_E; 5'd8: g = G_R;
        5'd9:  g = G_O; 5'd10: g = G_E;
        default: g = G_BL;
      endcase
    end
    return g;
  endfunction

  // Next-state logic: game-state changes override the divider/hold/scroll flow
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    hold_nx    = hold_cnt;
    sel_nx     = msg_sel;
    wrap_nx    = 1'b0;
    tick       = (cnt == CNT_MAX);
    req_active = (bus.presente == P_WLCM) || (bus.presente == P_CH);
    req_sel    = (bus.presente == P_CH);

    if (!req_active) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
      hold_nx  = '0;
    end else if (state == S_IDLE || req_sel != msg_sel) begin
      // Entry from IDLE or a switch between the two texts restarts the hold
      state_nx = S_HOLD;
      cnt_nx   = '0;
      idx_nx   = '0;
      hold_nx  = '0;
      sel_nx   = req_sel;
    end else begin
      cnt_nx = tick ? '0 : cnt + 1'b1;
      case (state)
        S_HOLD: begin
          if (tick) begin
            if (hold_cnt == HOLD_MAX) begin
              hold_nx  = '0;
              state_nx = S_SCROLL;
            end else begin
              hold_nx = hold_cnt + 4'd1;
            end
          end
        end
        S_SCROLL: begin
          if (tick) begin
            if (idx == ((msg_sel ? LEN_CH : LEN_WLCM) - 4'd1)) begin
              idx_nx   = '0;
              wrap_nx  = 1'b1;
              state_nx = S_HOLD;
            end else begin
              idx_nx = idx + 4'd1;
            end
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
          hold_nx  = '0;
        end
      endcase
    end
  end

  // Window of four glyphs at the current index; modulo by compare/subtract
  always_comb begin
    logic [4:0] pos;
    logic [4:0] len;
    disp_nx = '0;
    len     = {1'b0, (msg_sel ? LEN_CH : LEN_WLCM)};
    for (int k = 0; k < 4; k++) begin
      pos = {1'b0, idx} + 5'(k);
      if (pos >= len) pos = pos - len;
      disp_nx[27 - 7*k -: 7] = glyph(msg_sel, pos);
    end
    if (state == S_IDLE) disp_nx = '0;
`ifdef MENU_BLINK_EN
    // Blank the second half of each tick period while resting at index 0
    if (state == S_HOLD && cnt >= CW'(SCROLL_DIV / 2)) disp_nx = '0;
`endif
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      hold_cnt <= '0;
      msg_sel  <= 1'b0;
      wrap_q   <= 1'b0;
      disp_q   <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      idx      <= idx_nx;
      hold_cnt <= hold_nx;
      msg_sel  <= sel_nx;
      wrap_q   <= wrap_nx;
      disp_q   <= disp_nx;
    end
  end

  assign bus.display_menu = disp_q;
  assign bus.scroll_wrap  = wrap_q;

endmodule

`default_nettype wire

// File: doc/menu_scroller.md
Name: menu_scroller

Overview:
- Upstream feeder of the 8-digit display driver's 28-bit menu bus.
- Generates scrolling 4-character 7-segment text windows for the welcome (WLCM) and character-select (CH) states of the game state machine.
- Outputs blank in every other state.
- Pure sequential text engine: tick divider, scroll index, hold phase, registered glyph output.

Parameters:
- SCROLL_DIV, 13_500_000: clk cycles per scroll step (0.5 s at 27 MHz); minimum legal value 2.
- HOLD_STEPS, 2: scroll steps the window rests at index 0 before scrolling starts; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- presente  input  3  current game state: OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5.
- display_menu  output  28  four glyphs, active-high segments. [27:21]=leftmost digit, [6:0]=rightmost digit.
- scroll_wrap  output  1  one-cycle pulse when the index wraps from LEN-1 to 0.

Behaviour:
- Glyph encoding, bit6..bit0 = segments a..g:
  - H=0110111, O=1111110, L=0001110, A=1110111, E=1001111
  - r=0000101, I=0110000, G=1011110, blank=0000000
- Messages, held in constant ROM:
  - WLCM: "HOLA HErOE" followed by 3 blanks, LEN=13.
  - CH: "ELIGE HErOE" followed by 3 blanks, LEN=14.
- Window: digit k (k=0 leftmost) = msg[(idx+k) mod LEN]. The modulo is an explicit compare/subtract; there is no divider.
- Divider:
  - cnt counts 0..SCROLL_DIV-1.
  - tick is asserted for one cycle when cnt==SCROLL_DIV-1; cnt wraps to 0 on the same cycle.
- FSM states: IDLE, HOLD, SCROLL.
  - IDLE: presente not WLCM/CH. cnt=0, idx=0, hold_cnt=0, display_menu=0.
  - IDLE -> HOLD when presente becomes WLCM or CH.
  - HOLD: idx=0. hold_cnt increments on tick. When hold_cnt==HOLD_STEPS-1 and tick occurs: hold_cnt clears and the FSM moves to SCROLL.
  - SCROLL: idx increments on each tick.
  - SCROLL -> HOLD on the tick where idx==LEN-1. On that tick idx becomes 0 and scroll_wrap pulses for that single cycle.
- Change of presente between WLCM and CH, any state:
  - Next cycle: FSM=HOLD, idx=0, cnt=0, hold_cnt=0.
  - Message selects the new text.
- Change of presente to any other value: next cycle FSM=IDLE, all counters cleared.
- display_menu is registered:
  - It reflects idx/message one cycle after they change.
  - First valid window appears 1 cycle after entering HOLD. From IDLE, entering HOLD takes 1 cycle, so the window appears 2 cycles after presente changes.
- Reset (async, any time): FSM=IDLE, cnt=0, idx=0, hold_cnt=0, display_menu=0, scroll_wrap=0. Reset mid-scroll discards position; after release the scroll restarts at HOLD with idx 0.
- Unused presente codes 6,7: treated as IDLE.

Optional Feature:
- Macro: MENU_BLINK_EN.
- Defined: while FSM=HOLD, display_menu is forced to 0 whenever cnt >= SCROLL_DIV/2, giving a blinking first frame. SCROLL is unaffected.
- Not defined: HOLD output is steady. No blink logic or comparator is synthesised.

Test Plan (SCROLL_DIV=4, HOLD_STEPS=2):
- Reset release with presente=0 -> display_menu=0 and scroll_wrap=0 for 100 cycles.
- presente=1 at cycle 0 -> from cycle 2, display_menu={H,O,L,A} = 0110111_1111110_0001110_1110111, held 8 cycles. Next tick -> {O,L,A,blank}.
- presente=1 held through a full loop -> scroll_wrap pulses exactly once per 4*(2+13)=60 cycles. Window returns to {H,O,L,A} after each pulse.
- presente switched 1->2 mid-scroll (idx=5) -> next cycle idx=0. One cycle later display_menu={E,L,I,G} = 1001111_0001110_0110000_1011110.
- rst_n pulsed low mid-SCROLL for 1 cycle, presente=2 held -> outputs 0 asynchronously. After release the scroll restarts at {E,L,I,G} with full hold.
- MENU_BLINK_EN defined, presente=1 -> during HOLD, display_menu alternates 2 cycles HOLA / 2 cycles 0. Output is steady once in SCROLL.
